// File: rtl/hazard_interlock_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | hazard_interlock_if : decode-stage hazard/interlock signal bundle       |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface hazard_interlock_if #(
  parameter int CNT_W = 16
) ();
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_md;
  logic             ex_load;
  logic [4:0]       ex_wr_rn;
  logic             md_start;
  logic             md_is_div;
  logic             ext_pause;
  logic             cnt_clr;
  logic             pause;
  logic             ex_bubble;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md, ex_load, ex_wr_rn,
           md_start, md_is_div, ext_pause, cnt_clr,
    output pause, ex_bubble, md_busy, md_done, stall_cnt
  );

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md, ex_load, ex_wr_rn,
           md_start, md_is_div, ext_pause, cnt_clr,
    input  pause, ex_bubble, md_busy, md_done, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_interlock.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | hazard_interlock : load-use / mul-div interlock with stall counter      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module hazard_interlock #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_interlock_if.slave   bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  // A latency of 1 would give a zero-width counter; keep at least one bit.
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu;
  logic             mdh;
  logic             pause;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    lu = bus.ex_load && (bus.ex_wr_rn != 5'd0) &&
         ((bus.id_use_rs && (bus.id_rs == bus.ex_wr_rn)) ||
          (bus.id_use_rt && (bus.id_rt == bus.ex_wr_rn)));
    mdh   = bus.id_md && (state_q == RUN);
    pause = lu || mdh || bus.ext_pause;
  end

  // The MD unit runs independently of ext_pause; md_start while RUN is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.md_start) begin
          state_d = RUN;
          cnt_d   = bus.md_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
    end else if (pause && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pause     = pause;
  assign bus.ex_bubble = (lu || mdh) && !bus.ext_pause;
  assign bus.md_busy   = (state_q == RUN);
  assign bus.md_done   = (state_q == RUN) && (cnt_q == '0);
  assign bus.stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_interlock.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_hazard_interlock : self-checking bench for hazard_interlock          |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_hazard_interlock;

  localparam int A_MUL = 4;
  localparam int A_DIV = 33;
  localparam int B_MUL = 1;
  localparam int B_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs, id_rt, ex_wr_rn;
  logic       id_use_rs, id_use_rt, id_md, ex_load;
  logic       md_start, md_is_div, ext_pause, cnt_clr;

  int errors = 0;
  int checks = 0;
  // Reference: remaining busy cycles of the MD unit and stall totals.
  int rem_a = 0, rem_b = 0, stall_a = 0, stall_b = 0;

  always #5 clk = ~clk;

  hazard_interlock_if #(.CNT_W(16)) ifa ();
  hazard_interlock_if #(.CNT_W(4))  ifb ();

  assign ifa.id_rs = id_rs;         assign ifb.id_rs = id_rs;
  assign ifa.id_rt = id_rt;         assign ifb.id_rt = id_rt;
  assign ifa.id_use_rs = id_use_rs; assign ifb.id_use_rs = id_use_rs;
  assign ifa.id_use_rt = id_use_rt; assign ifb.id_use_rt = id_use_rt;
  assign ifa.id_md = id_md;         assign ifb.id_md = id_md;
  assign ifa.ex_load = ex_load;     assign ifb.ex_load = ex_load;
  assign ifa.ex_wr_rn = ex_wr_rn;   assign ifb.ex_wr_rn = ex_wr_rn;
  assign ifa.md_start = md_start;   assign ifb.md_start = md_start;
  assign ifa.md_is_div = md_is_div; assign ifb.md_is_div = md_is_div;
  assign ifa.ext_pause = ext_pause; assign ifb.ext_pause = ext_pause;
  assign ifa.cnt_clr = cnt_clr;     assign ifb.cnt_clr = cnt_clr;

  hazard_interlock #(.MUL_CYCLES(A_MUL), .DIV_CYCLES(A_DIV), .CNT_W(16)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  hazard_interlock #(.MUL_CYCLES(B_MUL), .DIV_CYCLES(B_DIV), .CNT_W(4)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  function automatic bit lu_exp();
    return ex_load && (ex_wr_rn != 0) &&
           ((id_use_rs && id_rs == ex_wr_rn) || (id_use_rt && id_rt == ex_wr_rn));
  endfunction

  function automatic bit pause_exp(int rem);
    return lu_exp() || (id_md && rem > 0) || ext_pause;
  endfunction

  function automatic bit bubble_exp(int rem);
    return (lu_exp() || (id_md && rem > 0)) && !ext_pause;
  endfunction

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; ex_wr_rn = 0;
    id_use_rs = 0; id_use_rt = 0; id_md = 0; ex_load = 0;
    md_start = 0; md_is_div = 0; ext_pause = 0; cnt_clr = 0;
  endtask

  // Advance one clock edge and update the reference, returning at the negedge.
  task automatic tick();
    bit pa, pb;
    @(posedge clk);
    pa = pause_exp(rem_a);
    pb = pause_exp(rem_b);
    if (rst) begin
      stall_a = cnt_clr ? 0 : ((pa && stall_a < 65535) ? stall_a + 1 : stall_a);
      stall_b = cnt_clr ? 0 : ((pb && stall_b < 15) ? stall_b + 1 : stall_b);
      if (rem_a > 0) rem_a--;
      else if (md_start) rem_a = md_is_div ? A_DIV : A_MUL;
      if (rem_b > 0) rem_b--;
      else if (md_start) rem_b = md_is_div ? B_DIV : B_MUL;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst = 1'b0;
    rem_a = 0; rem_b = 0; stall_a = 0; stall_b = 0;
    @(negedge clk);
    #1;
    checks++; if (ifa.md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", ifa.md_busy); end
    checks++; if (ifa.md_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", ifa.md_done); end
    checks++; if (ifa.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", ifa.stall_cnt); end
    checks++; if (ifa.pause !== 1'b0) begin errors++; $display("FAIL reset_pause got=%0b exp=0", ifa.pause); end
    ext_pause = 1; id_md = 1;
    #1;
    checks++; if (ifa.pause !== 1'b1) begin errors++; $display("FAIL reset_ext_pause got=%0b exp=1", ifa.pause); end
    checks++; if (ifa.ex_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got=%0b exp=0", ifa.ex_bubble); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    ex_load = 1; ex_wr_rn = 5; id_rs = 5; id_use_rs = 1;
    #1;
    checks++; if (ifa.pause !== 1'b1) begin errors++; $display("FAIL lu_pause got=%0b exp=1", ifa.pause); end
    checks++; if (ifa.ex_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble got=%0b exp=1", ifa.ex_bubble); end
    checks++; if (ifa.stall_cnt !== 16'd0) begin errors++; $display("FAIL lu_stall_before got=%0d exp=0", ifa.stall_cnt); end
    tick();
    ex_load = 0;
    #1;
    checks++; if (ifa.pause !== 1'b0) begin errors++; $display("FAIL lu_release got=%0b exp=0", ifa.pause); end
    checks++; if (ifa.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_after got=%0d exp=1", ifa.stall_cnt); end
    idle_inputs();
    tick();
  endtask

  task automatic test_r0_unused();
    ex_load = 1; ex_wr_rn = 0; id_rt = 0; id_use_rt = 1; id_rs = 0; id_use_rs = 1;
    #1;
    checks++; if (ifa.pause !== 1'b0) begin errors++; $display("FAIL r0_pause got=%0b exp=0", ifa.pause); end
    ex_wr_rn = 7; id_rt = 7; id_use_rt = 0; id_rs = 3;
    #1;
    checks++; if (ifa.pause !== 1'b0) begin errors++; $display("FAIL unused_rt_pause got=%0b exp=0", ifa.pause); end
    id_use_rt = 1;
    #1;
    checks++; if (ifa.pause !== 1'b1) begin errors++; $display("FAIL used_rt_pause got=%0b exp=1", ifa.pause); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_multiply();
    md_start = 1; md_is_div = 0;
    tick();
    md_start = 0; id_md = 1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++; if (ifa.md_busy !== (k <= 4)) begin errors++; $display("FAIL mul_busy k=%0d got=%0b exp=%0b", k, ifa.md_busy, k <= 4); end
      checks++; if (ifa.md_done !== (k == 4)) begin errors++; $display("FAIL mul_done k=%0d got=%0b exp=%0b", k, ifa.md_done, k == 4); end
      checks++; if (ifa.pause !== (k <= 4)) begin errors++; $display("FAIL mul_pause k=%0d got=%0b exp=%0b", k, ifa.pause, k <= 4); end
      // Single-cycle multiply on the second instance: busy and done together in t+1.
      checks++; if (ifb.md_done !== (k == 1)) begin errors++; $display("FAIL mul1_done k=%0d got=%0b exp=%0b", k, ifb.md_done, k == 1); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_divide_reset();
    md_start = 1; md_is_div = 1;
    tick();
    md_start = 0; id_md = 1;
    repeat (9) tick();
    #1;
    checks++; if (ifa.md_busy !== 1'b1) begin errors++; $display("FAIL div_busy got=%0b exp=1", ifa.md_busy); end
    checks++; if (ifa.stall_cnt === 16'd0) begin errors++; $display("FAIL div_stall_nonzero got=%0d exp=nonzero", ifa.stall_cnt); end
    rst = 1'b0;
    rem_a = 0; rem_b = 0; stall_a = 0; stall_b = 0;
    #1;
    checks++; if (ifa.md_busy !== 1'b0) begin errors++; $display("FAIL div_rst_busy got=%0b exp=0", ifa.md_busy); end
    checks++; if (ifa.md_done !== 1'b0) begin errors++; $display("FAIL div_rst_done got=%0b exp=0", ifa.md_done); end
    checks++; if (ifa.stall_cnt !== 16'd0) begin errors++; $display("FAIL div_rst_stall got=%0d exp=0", ifa.stall_cnt); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (ifa.md_done !== 1'b0) begin errors++; $display("FAIL div_post_done k=%0d got=%0b exp=0", k, ifa.md_done); end
      tick();
    end
  endtask

  task automatic test_ext_pause();
    md_start = 1; md_is_div = 0;
    tick();
    md_start = 0; ext_pause = 1;
    ex_load = 1; ex_wr_rn = 9; id_rt = 9; id_use_rt = 1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++; if (ifa.pause !== 1'b1) begin errors++; $display("FAIL ext_pause k=%0d got=%0b exp=1", k, ifa.pause); end
      checks++; if (ifa.ex_bubble !== 1'b0) begin errors++; $display("FAIL ext_bubble k=%0d got=%0b exp=0", k, ifa.ex_bubble); end
      checks++; if (ifa.md_busy !== (k <= 4)) begin errors++; $display("FAIL ext_busy k=%0d got=%0b exp=%0b", k, ifa.md_busy, k <= 4); end
      checks++; if (ifa.md_done !== (k == 4)) begin errors++; $display("FAIL ext_done k=%0d got=%0b exp=%0b", k, ifa.md_done, k == 4); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    cnt_clr = 1;
    tick();
    cnt_clr = 0; ext_pause = 1;
    repeat (20) tick();
    #1;
    checks++; if (ifb.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_value got=%0d exp=15", ifb.stall_cnt); end
    checks++; if (ifa.stall_cnt !== 16'(stall_a)) begin errors++; $display("FAIL sat_wide got=%0d exp=%0d", ifa.stall_cnt, stall_a); end
    cnt_clr = 1;
    tick();
    #1;
    checks++; if (ifb.stall_cnt !== 4'd0) begin errors++; $display("FAIL clr_priority got=%0d exp=0", ifb.stall_cnt); end
    checks++; if (ifa.stall_cnt !== 16'd0) begin errors++; $display("FAIL clr_wide got=%0d exp=0", ifa.stall_cnt); end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      id_rs     = 5'($urandom_range(0, 3));
      id_rt     = 5'($urandom_range(0, 3));
      ex_wr_rn  = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom_range(0, 1));
      id_use_rt = 1'($urandom_range(0, 1));
      ex_load   = 1'($urandom_range(0, 1));
      id_md     = ($urandom_range(0, 3) == 0);
      md_start  = ($urandom_range(0, 7) == 0);
      md_is_div = 1'($urandom_range(0, 1));
      ext_pause = ($urandom_range(0, 5) == 0);
      cnt_clr   = ($urandom_range(0, 19) == 0);
      #1;
      checks++; if (ifa.pause !== pause_exp(rem_a)) begin errors++; $display("FAIL rnd_a_pause n=%0d got=%0b exp=%0b", n, ifa.pause, pause_exp(rem_a)); end
      checks++; if (ifa.ex_bubble !== bubble_exp(rem_a)) begin errors++; $display("FAIL rnd_a_bubble n=%0d got=%0b exp=%0b", n, ifa.ex_bubble, bubble_exp(rem_a)); end
      checks++; if (ifa.md_busy !== (rem_a > 0)) begin errors++; $display("FAIL rnd_a_busy n=%0d got=%0b exp=%0b", n, ifa.md_busy, rem_a > 0); end
      checks++; if (ifa.md_done !== (rem_a == 1)) begin errors++; $display("FAIL rnd_a_done n=%0d got=%0b exp=%0b", n, ifa.md_done, rem_a == 1); end
      checks++; if (ifa.stall_cnt !== 16'(stall_a)) begin errors++; $display("FAIL rnd_a_stall n=%0d got=%0d exp=%0d", n, ifa.stall_cnt, stall_a); end
      checks++; if (ifb.pause !== pause_exp(rem_b)) begin errors++; $display("FAIL rnd_b_pause n=%0d got=%0b exp=%0b", n, ifb.pause, pause_exp(rem_b)); end
      checks++; if (ifb.ex_bubble !== bubble_exp(rem_b)) begin errors++; $display("FAIL rnd_b_bubble n=%0d got=%0b exp=%0b", n, ifb.ex_bubble, bubble_exp(rem_b)); end
      checks++; if (ifb.md_busy !== (rem_b > 0)) begin errors++; $display("FAIL rnd_b_busy n=%0d got=%0b exp=%0b", n, ifb.md_busy, rem_b > 0); end
      checks++; if (ifb.md_done !== (rem_b == 1)) begin errors++; $display("FAIL rnd_b_done n=%0d got=%0b exp=%0b", n, ifb.md_done, rem_b == 1); end
      checks++; if (ifb.stall_cnt !== 4'(stall_b)) begin errors++; $display("FAIL rnd_b_stall n=%0d got=%0d exp=%0d", n, ifb.stall_cnt, stall_b); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_r0_unused();
    test_multiply();
    test_divide_reset();
    test_ext_pause();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
